// File: rtl/seq_detect_pkg.sv
// Shared constants for the parameterised serial sequence detector.
package seq_detect_pkg;

    // Legal range of the pattern length parameter.
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Encodings of the overlap input.
    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    // Width of a counter that must hold 0..pat_w-1.
    function automatic int fill_width(input int pat_w);
        return (pat_w > 2) ? $clog2(pat_w) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky "reached maximum" flag.
// clr has priority over inc; once cnt is all-ones it holds there.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);

    // Count up on inc, stop at the maximum, raise sat on the step that reaches it.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_NEAR) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Loadable serial pattern detector. The last PAT_W-1 consumed bits sit in
// hist; the current bit w completes the window compared against pat. fill
// counts how many valid bits hist holds since the last restart, so a match
// can only fire once a full pattern has been seen after load/reset.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w,
    input  logic             en,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap,
    input  logic             clear,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat
);

    localparam int                FILL_W   = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    // An out-of-range PAT_W stops elaboration on a module that does not exist.
    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        seq_detect_illegal_pat_w u_stop ();
    end

    logic [PAT_W-1:0]  pat;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    // Oldest history bit lands in the MSB, matching "MSB is the first bit expected".
    assign window = {hist, w};

    // Mealy match on the bit being presented this cycle.
    // NOTE: out is gated by rst_n so nothing can be counted or registered while
    // the block is held in reset, even though the rest of out is pure logic.
    always_comb begin
        out = rst_n & en & ~load & (fill == FILL_MAX) & (window == pat);
    end

    // Pattern, history and fill tracking: load restarts, en consumes a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat  <= '0;
            hist <= '0;
            fill <= '0;
        end else if (load) begin
            pat  <= pattern_in;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            if (out && (overlap == OVL_OFF)) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // Registered copy of the match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out),
        .clr  (clear),
        .cnt  (match_cnt),
        .sat  (sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus randomized stimulus,
// all checked against a queue-based model of "bits seen since last restart".
module tb_seq_detect_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_W_S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic w = 1'b0, en = 1'b0, load = 1'b0, overlap = 1'b0, clear = 1'b0;
    logic [PAT_W-1:0] pattern_in = '0;

    logic               out, out_q, sat;
    logic [CNT_W-1:0]   match_cnt;
    logic               out_s, out_q_s, sat_s;
    logic [CNT_W_S-1:0] match_cnt_s;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .w(w), .en(en), .load(load),
        .pattern_in(pattern_in), .overlap(overlap), .clear(clear),
        .out(out), .out_q(out_q), .match_cnt(match_cnt), .sat(sat)
    );

    // Narrow-counter instance on the same stimulus to reach saturation quickly.
    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W_S)) u_sat (
        .clk(clk), .rst_n(rst_n), .w(w), .en(en), .load(load),
        .pattern_in(pattern_in), .overlap(overlap), .clear(clear),
        .out(out_s), .out_q(out_q_s), .match_cnt(match_cnt_s), .sat(sat_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: the pattern, the consumed bits since the last restart
    // (only the newest PAT_W-1 matter), matches since the last clear, and the
    // previous cycle's match.
    logic [PAT_W-1:0] m_pat = '0;
    logic             m_bits[$];
    int unsigned      m_matches = 0;
    logic             m_prev = 1'b0;

    function automatic logic model_out(input logic w_i, input logic en_i, input logic load_i);
        logic [PAT_W-1:0] win;
        if (!rst_n || !en_i || load_i || (m_bits.size() < PAT_W - 1)) return 1'b0;
        for (int i = 0; i < PAT_W - 1; i++) win[PAT_W-1-i] = m_bits[i];
        win[0] = w_i;
        return win == m_pat;
    endfunction

    function automatic int unsigned sat_min(input int unsigned v, input int cw);
        int unsigned mx = (1 << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_regs();
        check("out_q", out_q, m_prev);
        check("match_cnt", match_cnt, sat_min(m_matches, CNT_W));
        check("sat", sat, m_matches >= (1 << CNT_W) - 1);
        check("match_cnt_narrow", match_cnt_s, sat_min(m_matches, CNT_W_S));
        check("sat_narrow", sat_s, m_matches >= (1 << CNT_W_S) - 1);
    endtask

    // One clock of stimulus: drive at negedge, check out mid-cycle, check
    // registered outputs just after the rising edge.
    task automatic step(input logic w_i, input logic en_i, input logic load_i,
                        input logic [PAT_W-1:0] pat_i, input logic ovl_i,
                        input logic clr_i, output logic got_out);
        logic exp;
        @(negedge clk);
        w = w_i; en = en_i; load = load_i; pattern_in = pat_i;
        overlap = ovl_i; clear = clr_i;
        #1;
        exp = model_out(w_i, en_i, load_i);
        check("out", out, exp);
        check("out_narrow", out_s, exp);
        got_out = out;
        @(posedge clk);
        #1;
        if (load_i) begin
            m_pat = pat_i;
            m_bits.delete();
        end else if (en_i) begin
            if (exp && !ovl_i) begin
                m_bits.delete();
            end else begin
                m_bits.push_back(w_i);
                if (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
            end
        end
        if (clr_i) m_matches = 0;
        else if (exp) m_matches++;
        m_prev = exp;
        check_regs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; w = 1'b1; load = 1'b0; clear = 1'b0;
        #1;
        check("out_in_reset", out, 0);
        m_pat = '0; m_bits.delete(); m_matches = 0; m_prev = 1'b0;
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        en = 1'b0; w = 1'b0;
        rst_n = 1'b1;
    endtask

    // Convenience: feed a bit with en=1, no load, no clear, current overlap.
    task automatic feed(input logic b, output logic o);
        step(b, 1'b1, 1'b0, pattern_in, overlap, 1'b0, o);
    endtask

    task automatic load_pat(input logic [PAT_W-1:0] p, input logic ovl);
        logic o;
        step(1'b0, 1'b0, 1'b1, p, ovl, 1'b1, o);
    endtask

    initial begin
        logic       o;
        logic [7:0] vec;

        do_reset();

        // Overlapping 1111 on six 1s: matches on bits 4, 5 and 6.
        load_pat(4'b1111, 1'b1);
        vec = '0;
        for (int i = 0; i < 6; i++) begin feed(1'b1, o); vec = {vec[6:0], o}; end
        check("ovl_out_seq", vec[5:0], 6'b000111);
        check("ovl_cnt", match_cnt, 3);

        // Same stream without overlap: a single match on bit 4.
        load_pat(4'b1111, 1'b0);
        vec = '0;
        for (int i = 0; i < 6; i++) begin feed(1'b1, o); vec = {vec[6:0], o}; end
        check("novl_out_seq", vec[5:0], 6'b000100);
        check("novl_cnt", match_cnt, 1);

        // Enable gap: the gated bit is not consumed.
        load_pat(4'b1011, 1'b0);
        vec = '0;
        feed(1'b1, o); vec = {vec[6:0], o};
        feed(1'b0, o); vec = {vec[6:0], o};
        step(1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0, o); vec = {vec[6:0], o};
        feed(1'b1, o); vec = {vec[6:0], o};
        feed(1'b1, o); vec = {vec[6:0], o};
        check("gap_out_seq", vec[4:0], 5'b00001);
        check("gap_cnt", match_cnt, 1);

        // Saturation of the 2-bit counter, then clear.
        load_pat(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) feed(1'b1, o);
        check("sat_cnt_narrow", match_cnt_s, 3);
        check("sat_flag_narrow", sat_s, 1);
        step(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, o);
        check("sat_clr_cnt", match_cnt_s, 0);
        check("sat_clr_flag", sat_s, 0);

        // Reset mid-stream: a full pattern is needed afterwards.
        load_pat(4'b1011, 1'b0);
        feed(1'b1, o); feed(1'b0, o); feed(1'b1, o);
        do_reset();
        load_pat(4'b1011, 1'b0);
        vec = '0;
        feed(1'b1, o); vec = {vec[6:0], o};
        feed(1'b0, o); vec = {vec[6:0], o};
        feed(1'b1, o); vec = {vec[6:0], o};
        feed(1'b1, o); vec = {vec[6:0], o};
        check("rst_out_seq", vec[3:0], 4'b0001);

        // Mid-stream load restarts fill: 0110 must not match on stale history.
        load_pat(4'b1011, 1'b0);
        feed(1'b1, o); feed(1'b0, o); feed(1'b1, o);
        load_pat(4'b0110, 1'b0);
        vec = '0;
        feed(1'b1, o); vec = {vec[6:0], o};
        feed(1'b0, o); vec = {vec[6:0], o};
        check("midload_out_seq", vec[1:0], 2'b00);

        // Randomized traffic; patterns kept in a small set so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic r_en, r_load, r_clr, r_ovl;
            logic [PAT_W-1:0] r_pat;
            if ($urandom_range(0, 399) == 0) do_reset();
            r_en   = ($urandom_range(0, 9) < 8);
            r_load = ($urandom_range(0, 39) == 0);
            r_clr  = ($urandom_range(0, 49) == 0);
            r_ovl  = ($urandom_range(0, 19) == 0) ? ~overlap : overlap;
            r_pat  = PAT_W'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), r_en, r_load, r_pat, r_ovl, r_clr, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on simulation time so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
